// File: rtl/fft_frame_sequencer.sv
// fft_frame_sequencer
// Frame-level controller for the cascaded FFT butterfly chain. Accepts beats
// over a valid/ready handshake, enforces contiguous COUNT-beat frames, and
// sequences per-stage valid / butterfly-select strobes through a tagged
// shift register. Short frames are aborted and their beats killed in flight
// without disturbing the previous, complete frame.
//
// Ports
//   clk, rst     single clock, synchronous active-high reset
//   in_valid     upstream beat valid
//   in_ready     sequencer can accept a beat (low only while flushing)
//   beat_idx     index of the beat accepted this cycle (combinational)
//   stage_vld    per-stage valid_in strobe to butterfly k
//   stage_sel    per-stage bfly_en: 1 = compute, 0 = pass delayed data
//   out_vld      chain output beat valid
//   out_last     chain output beat is the last beat of its frame
//   frame_done   completed-frame pulse (out_vld & out_last)
//   err_short    one-cycle pulse after a frame is aborted
//   frame_cnt    completed frames, wraps modulo 2^CNT_W
//   busy         FSM not idle or any pipeline slot valid
module fft_frame_sequencer #(
    parameter int unsigned NUM        = 16,
    parameter int unsigned DATA       = 64,
    parameter int unsigned COUNT      = DATA / NUM,
    parameter int unsigned NUM_STAGES = $clog2(COUNT),
    parameter int unsigned STAGE_LAT  = 3,
    parameter int unsigned CNT_W      = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    output logic [$clog2(COUNT)-1:0] beat_idx,
    output logic [NUM_STAGES-1:0]    stage_vld,
    output logic [NUM_STAGES-1:0]    stage_sel,
    output logic                     out_vld,
    output logic                     out_last,
    output logic                     frame_done,
    output logic                     err_short,
    output logic [CNT_W-1:0]         frame_cnt,
    output logic                     busy
);

    localparam int unsigned BW    = $clog2(COUNT);
    localparam int unsigned DEPTH = NUM_STAGES * STAGE_LAT + 1;
    localparam logic [BW-1:0] LAST_BEAT = BW'(COUNT - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic [BW-1:0]   beat_cnt;
    logic [BW-1:0]   flush_cnt;
    logic            tag;
    logic            tag_cur;
    logic            accept;
    logic            abort;
    logic            frame_start;

    // Pipeline slots; the tag of the final slot is never needed, so it is not kept
    logic [DEPTH-1:0] slot_vld;
    logic [DEPTH-2:0] slot_tag;
    logic [BW-1:0]    slot_beat [DEPTH];
    logic [DEPTH-2:0] kill;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = RUN;
            RUN:     if (!accept) state_nxt = (beat_cnt == '0) ? IDLE : FLUSH;
            FLUSH:   if (flush_cnt == LAST_BEAT) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // FSM outputs and handshake decode
    always_comb begin
        in_ready    = (state != FLUSH);
        accept      = in_valid & in_ready;
        abort       = (state == RUN) && !accept && (beat_cnt != '0);
        frame_start = accept && (beat_cnt == '0);
        tag_cur     = frame_start ? ~tag : tag;
        beat_idx    = beat_cnt;
    end

    // Aborted beats are the most recent beat_cnt accepts, i.e. the youngest
    // beat_cnt slots; restricting the kill to them keeps an older frame with
    // the same (aliased) tag from being hit.
    always_comb begin
        kill = '0;
        for (int i = 0; i < int'(DEPTH - 1); i++) begin
            kill[i] = abort && (slot_tag[i] == tag) && (i < int'(beat_cnt));
        end
    end

    // Beat counter, frame tag, flush timer, error pulse and frame counter
    always_ff @(posedge clk) begin
        if (rst) begin
            beat_cnt  <= '0;
            flush_cnt <= '0;
            tag       <= 1'b0;
            err_short <= 1'b0;
            frame_cnt <= '0;
        end else begin
            if (abort) begin
                beat_cnt <= '0;
            end else if (accept) begin
                beat_cnt <= beat_cnt + BW'(1);
            end
            if (frame_start) begin
                tag <= ~tag;
            end
            flush_cnt <= (state == FLUSH) ? flush_cnt + BW'(1) : '0;
            err_short <= abort;
            if (frame_done) begin
                frame_cnt <= frame_cnt + CNT_W'(1);
            end
        end
    end

    // Tagged pipeline shift register
    always_ff @(posedge clk) begin
        if (rst) begin
            slot_vld <= '0;
            slot_tag <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                slot_beat[i] <= '0;
            end
        end else begin
            slot_vld[0]  <= accept;
            slot_tag[0]  <= tag_cur;
            slot_beat[0] <= beat_cnt;
            for (int i = 1; i < int'(DEPTH); i++) begin
                slot_vld[i]  <= slot_vld[i-1] & ~kill[i-1];
                slot_beat[i] <= slot_beat[i-1];
            end
            for (int i = 1; i < int'(DEPTH - 1); i++) begin
                slot_tag[i] <= slot_tag[i-1];
            end
        end
    end

    // Stage k taps the slot STAGE_LAT*k deep; its select is the beat-index bit
    // that distinguishes butterfly partners at that stage (MSB first)
    for (genvar k = 0; k < int'(NUM_STAGES); k++) begin : g_stage
        assign stage_vld[k] = slot_vld[k * STAGE_LAT];
        assign stage_sel[k] = slot_beat[k * STAGE_LAT][BW - 1 - k];
    end

    // Chain output and status
    assign out_vld    = slot_vld[DEPTH-1];
    assign out_last   = slot_vld[DEPTH-1] && (slot_beat[DEPTH-1] == LAST_BEAT);
    assign frame_done = out_last;
    assign busy       = (state != IDLE) || (|slot_vld);

endmodule

// File: tb/tb_fft_frame_sequencer.sv
// Directed testbench for fft_frame_sequencer at default parameters
// (COUNT=4, two stages, STAGE_LAT=3, CNT_W=8).
module tb_fft_frame_sequencer;

    logic       clk;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [1:0] beat_idx;
    logic [1:0] stage_vld;
    logic [1:0] stage_sel;
    logic       out_vld;
    logic       out_last;
    logic       frame_done;
    logic       err_short;
    logic [7:0] frame_cnt;
    logic       busy;

    int checks = 0;
    int errors = 0;

    fft_frame_sequencer dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .beat_idx   (beat_idx),
        .stage_vld  (stage_vld),
        .stage_sel  (stage_sel),
        .out_vld    (out_vld),
        .out_last   (out_last),
        .frame_done (frame_done),
        .err_short  (err_short),
        .frame_cnt  (frame_cnt),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance to just after the next rising edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst      = 1'b1;
        in_valid = 1'b1;
        tick();
        tick();
        rst      = 1'b0;
        in_valid = 1'b0;
        #1;
        checks++;
        if ({stage_vld, stage_sel, out_vld, out_last, frame_done, err_short, busy} !== 9'b0) begin
            errors++;
            $display("FAIL reset_outputs got=%b exp=0",
                     {stage_vld, stage_sel, out_vld, out_last, frame_done, err_short, busy});
        end
        checks++;
        if (frame_cnt !== 8'd0) begin
            errors++;
            $display("FAIL reset_frame_cnt got=%0d exp=0", frame_cnt);
        end
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_in_ready got=%b exp=1", in_ready);
        end
        tick();
        #1;
        checks++;
        if (busy !== 1'b0 || stage_vld !== 2'b00) begin
            errors++;
            $display("FAIL reset_nothing_accepted busy=%b stage_vld=%b exp busy=0 stage_vld=00",
                     busy, stage_vld);
        end
        tick();
    endtask

    task automatic test_single();
        for (int c = 0; c < 14; c++) begin
            in_valid = (c < 4);
            #1;
            if (c < 4) begin
                checks++;
                if (beat_idx !== 2'(c)) begin
                    errors++;
                    $display("FAIL single_beat_idx cyc=%0d got=%0d exp=%0d", c, beat_idx, c);
                end
            end
            checks++;
            if (stage_vld[0] !== (c >= 1 && c <= 4)) begin
                errors++;
                $display("FAIL single_stage_vld0 cyc=%0d got=%b", c, stage_vld[0]);
            end
            if (c >= 1 && c <= 4) begin
                checks++;
                if (stage_sel[0] !== 1'((c - 1) >> 1)) begin
                    errors++;
                    $display("FAIL single_stage_sel0 cyc=%0d got=%b exp=%b", c, stage_sel[0], 1'((c - 1) >> 1));
                end
            end
            checks++;
            if (stage_vld[1] !== (c >= 4 && c <= 7)) begin
                errors++;
                $display("FAIL single_stage_vld1 cyc=%0d got=%b", c, stage_vld[1]);
            end
            if (c >= 4 && c <= 7) begin
                checks++;
                if (stage_sel[1] !== 1'(c - 4)) begin
                    errors++;
                    $display("FAIL single_stage_sel1 cyc=%0d got=%b exp=%b", c, stage_sel[1], 1'(c - 4));
                end
            end
            checks++;
            if (out_vld !== (c >= 7 && c <= 10) || frame_done !== (c == 10) || out_last !== (c == 10)) begin
                errors++;
                $display("FAIL single_out cyc=%0d out_vld=%b out_last=%b frame_done=%b", c, out_vld, out_last, frame_done);
            end
            checks++;
            if (in_ready !== 1'b1 || err_short !== 1'b0) begin
                errors++;
                $display("FAIL single_ready_err cyc=%0d in_ready=%b err_short=%b exp 1/0", c, in_ready, err_short);
            end
            if (c == 11) begin
                checks++;
                if (frame_cnt !== 8'd1) begin
                    errors++;
                    $display("FAIL single_frame_cnt got=%0d exp=1", frame_cnt);
                end
            end
            tick();
        end
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL single_idle_busy got=%b exp=0", busy);
        end
    endtask

    task automatic test_back_to_back();
        for (int c = 0; c < 21; c++) begin
            in_valid = (c < 12);
            #1;
            if (c < 12) begin
                checks++;
                if (beat_idx !== 2'(c % 4) || in_ready !== 1'b1) begin
                    errors++;
                    $display("FAIL b2b_beat_idx cyc=%0d got=%0d exp=%0d in_ready=%b", c, beat_idx, c % 4, in_ready);
                end
            end
            if (c >= 1 && c <= 12) begin
                checks++;
                if (stage_vld[0] !== 1'b1 || stage_sel[0] !== 1'(((c - 1) % 4) >> 1)) begin
                    errors++;
                    $display("FAIL b2b_stage0 cyc=%0d vld=%b sel=%b", c, stage_vld[0], stage_sel[0]);
                end
            end
            checks++;
            if (out_vld !== (c >= 7 && c <= 18)) begin
                errors++;
                $display("FAIL b2b_out_vld cyc=%0d got=%b", c, out_vld);
            end
            checks++;
            if (frame_done !== (c == 10 || c == 14 || c == 18)) begin
                errors++;
                $display("FAIL b2b_frame_done cyc=%0d got=%b", c, frame_done);
            end
            checks++;
            if (err_short !== 1'b0) begin
                errors++;
                $display("FAIL b2b_err_short cyc=%0d got=%b exp=0", c, err_short);
            end
            tick();
        end
        checks++;
        if (frame_cnt !== 8'd4) begin
            errors++;
            $display("FAIL b2b_frame_cnt got=%0d exp=4", frame_cnt);
        end
    endtask

    task automatic test_short_frame();
        int err_pulses;
        err_pulses = 0;
        for (int c = 0; c < 16; c++) begin
            in_valid = (c < 6);
            #1;
            if (err_short === 1'b1) err_pulses++;
            checks++;
            if (in_ready !== !(c >= 7 && c <= 10)) begin
                errors++;
                $display("FAIL short_in_ready cyc=%0d got=%b", c, in_ready);
            end
            checks++;
            if (err_short !== (c == 7)) begin
                errors++;
                $display("FAIL short_err_short cyc=%0d got=%b", c, err_short);
            end
            checks++;
            if (stage_vld[1] !== (c >= 4 && c <= 7)) begin
                errors++;
                $display("FAIL short_stage_vld1 cyc=%0d got=%b", c, stage_vld[1]);
            end
            checks++;
            if (out_vld !== (c >= 7 && c <= 10) || frame_done !== (c == 10)) begin
                errors++;
                $display("FAIL short_out cyc=%0d out_vld=%b frame_done=%b", c, out_vld, frame_done);
            end
            tick();
        end
        checks++;
        if (err_pulses != 1 || frame_cnt !== 8'd5 || busy !== 1'b0) begin
            errors++;
            $display("FAIL short_summary pulses=%0d frame_cnt=%0d busy=%b exp 1/5/0", err_pulses, frame_cnt, busy);
        end
    endtask

    task automatic test_mid_reset();
        for (int c = 0; c < 18; c++) begin
            rst      = (c == 2);
            in_valid = (c < 3) || (c >= 4 && c <= 7);
            #1;
            if (c == 3) begin
                checks++;
                if (stage_vld !== 2'b00 || out_vld !== 1'b0 || busy !== 1'b0 || frame_cnt !== 8'd0) begin
                    errors++;
                    $display("FAIL midreset_clear stage_vld=%b out_vld=%b busy=%b frame_cnt=%0d", stage_vld, out_vld, busy, frame_cnt);
                end
                checks++;
                if (in_ready !== 1'b1) begin
                    errors++;
                    $display("FAIL midreset_in_ready got=%b exp=1", in_ready);
                end
            end
            if (c >= 4 && c <= 7) begin
                checks++;
                if (beat_idx !== 2'(c - 4)) begin
                    errors++;
                    $display("FAIL midreset_beat_idx cyc=%0d got=%0d exp=%0d", c, beat_idx, c - 4);
                end
            end
            if (c >= 4) begin
                checks++;
                if (out_vld !== (c >= 11 && c <= 14) || frame_done !== (c == 14)) begin
                    errors++;
                    $display("FAIL midreset_out cyc=%0d out_vld=%b frame_done=%b", c, out_vld, frame_done);
                end
            end
            if (c == 15) begin
                checks++;
                if (frame_cnt !== 8'd1) begin
                    errors++;
                    $display("FAIL midreset_frame_cnt got=%0d exp=1", frame_cnt);
                end
            end
            tick();
        end
        rst = 1'b0;
    endtask

    task automatic test_wrap();
        int  dones;
        int  errs;
        logic seen_max;
        dones    = 0;
        errs     = 0;
        seen_max = 1'b0;
        rst      = 1'b1;
        in_valid = 1'b0;
        tick();
        rst = 1'b0;
        for (int c = 0; c < 1040; c++) begin
            in_valid = (c < 1024);
            #1;
            if (frame_done === 1'b1) dones++;
            if (err_short === 1'b1) errs++;
            if (frame_cnt === 8'd255) seen_max = 1'b1;
            tick();
        end
        checks++;
        if (dones != 256 || errs != 0) begin
            errors++;
            $display("FAIL wrap_done_count got=%0d err_pulses=%0d exp 256/0", dones, errs);
        end
        checks++;
        if (seen_max !== 1'b1) begin
            errors++;
            $display("FAIL wrap_reached_255 got=%b exp=1", seen_max);
        end
        checks++;
        if (frame_cnt !== 8'd0) begin
            errors++;
            $display("FAIL wrap_frame_cnt got=%0d exp=0", frame_cnt);
        end
    endtask

    initial begin
        rst      = 1'b1;
        in_valid = 1'b0;
        test_reset();
        test_single();
        test_back_to_back();
        test_short_frame();
        test_mid_reset();
        test_wrap();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
